vc_req_ctrl: RTL

- Initiator-side sequencer for the victim cache (VC). It sits between the L1 miss path, the VC control port (vc_read/vc_write/rdata_exists) and physical memory.
- On an L1 miss it looks up the VC first and falls back to pmem on a VC miss. It then pushes the L1's evicted line into the VC and returns the fill line to the L1.
- One request in flight at a time.

---
 rtl/vc_req_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/vc_req_ctrl.sv
// Victim-cache request sequencer: VC lookup, pmem fallback, victim insert, then L1 fill.
// States: IDLE wait | VC_RD lookup | VC_CHK hit? | MEM_RD pmem | VC_WR_REQ insert | VC_WR_WAIT done? | FILL
module vc_req_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int S_LINE     = 256,
  parameter int WR_TIMEOUT = 16,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              l1_req,
  input  logic [ADDR_W-1:0] l1_req_addr,
  input  logic              l1_evict_valid,
  input  logic [ADDR_W-1:0] l1_evict_addr,
  input  logic [S_LINE-1:0] l1_evict_line,
  input  logic              l1_evict_dirty,
  output logic              l1_ready,
  output logic              l1_fill_valid,
  output logic [S_LINE-1:0] l1_fill_line,
  output logic              l1_fill_from_vc,
  output logic              vc_read,
  output logic              vc_write,
  output logic [ADDR_W-1:0] vc_address,
  output logic [S_LINE-1:0] vc_wdata,
  output logic              vc_wdata_dirty,
  input  logic              vc_rdata_exists,
  input  logic [S_LINE-1:0] vc_rdata,
  output logic              pmem_read,
  output logic [ADDR_W-1:0] pmem_address,
  input  logic [S_LINE-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              vc_wr_err,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int OFF_W = $clog2(S_LINE / 8);
  localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W - OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam int TO_W = (WR_TIMEOUT > 2) ? $clog2(WR_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(WR_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VC_RD, S_VC_CHK, S_MEM_RD, S_VC_WR_REQ, S_VC_WR_WAIT, S_FILL
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic                ev_valid_q, ev_valid_d;
  logic [ADDR_W-1:0]   ev_addr_q, ev_addr_d;
  logic [S_LINE-1:0]   ev_line_q, ev_line_d;
  logic                ev_dirty_q, ev_dirty_d;
  logic [S_LINE-1:0]   fill_line_q, fill_line_d;
  logic                from_vc_q, from_vc_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic                wr_err_q, wr_err_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_addr_q  <= '0;
      ev_valid_q  <= 1'b0;
      ev_addr_q   <= '0;
      ev_line_q   <= '0;
      ev_dirty_q  <= 1'b0;
      fill_line_q <= '0;
      from_vc_q   <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      wr_err_q    <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      ev_valid_q  <= ev_valid_d;
      ev_addr_q   <= ev_addr_d;
      ev_line_q   <= ev_line_d;
      ev_dirty_q  <= ev_dirty_d;
      fill_line_q <= fill_line_d;
      from_vc_q   <= from_vc_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      wr_err_q    <= wr_err_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    req_addr_d      = req_addr_q;
    ev_valid_d      = ev_valid_q;
    ev_addr_d       = ev_addr_q;
    ev_line_d       = ev_line_q;
    ev_dirty_d      = ev_dirty_q;
    fill_line_d     = fill_line_q;
    from_vc_d       = from_vc_q;
    hit_cnt_d       = hit_cnt_q;
    miss_cnt_d      = miss_cnt_q;
    wr_err_d        = wr_err_q;
    to_cnt_d        = to_cnt_q;
    l1_ready        = 1'b0;
    l1_fill_valid   = 1'b0;
    l1_fill_line    = '0;
    l1_fill_from_vc = 1'b0;
    vc_read         = 1'b0;
    vc_write        = 1'b0;
    vc_address      = '0;
    vc_wdata        = '0;
    vc_wdata_dirty  = 1'b0;
    pmem_read       = 1'b0;
    pmem_address    = '0;

    case (state_q)
      S_IDLE: begin
        l1_ready = 1'b1;
        if (l1_req) begin
          req_addr_d = l1_req_addr & ADDR_MASK;
          ev_valid_d = l1_evict_valid;
          ev_addr_d  = l1_evict_addr & ADDR_MASK;
          ev_line_d  = l1_evict_line;
          ev_dirty_d = l1_evict_dirty;
          state_d    = S_VC_RD;
        end
      end
      S_VC_RD: begin
        vc_read    = 1'b1;
        vc_address = req_addr_q;
        state_d    = S_VC_CHK;
      end
      S_VC_CHK: begin
        vc_address = req_addr_q;
        if (vc_rdata_exists) begin
          fill_line_d = vc_rdata;
          from_vc_d   = 1'b1;
          hit_cnt_d   = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + CNT_W'(1);
          state_d     = ev_valid_q ? S_VC_WR_REQ : S_FILL;
        end else begin
          miss_cnt_d  = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + CNT_W'(1);
          state_d     = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        pmem_read    = 1'b1;
        pmem_address = req_addr_q;
        if (pmem_resp) begin
          fill_line_d = pmem_rdata;
          from_vc_d   = 1'b0;
          state_d     = ev_valid_q ? S_VC_WR_REQ : S_FILL;
        end
      end
      S_VC_WR_REQ: begin
        vc_write       = 1'b1;
        vc_address     = ev_addr_q;
        vc_wdata       = ev_line_q;
        vc_wdata_dirty = ev_dirty_q;
        to_cnt_d       = '0;
        state_d        = S_VC_WR_WAIT;
      end
      S_VC_WR_WAIT: begin
        // Victim fields stay on the bus until the VC acknowledges or we give up.
        vc_address     = ev_addr_q;
        vc_wdata       = ev_line_q;
        vc_wdata_dirty = ev_dirty_q;
        if (vc_rdata_exists) begin
          state_d = S_FILL;
        end else if (to_cnt_q == TO_LAST) begin
          wr_err_d = 1'b1;
          state_d  = S_FILL;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_FILL: begin
        l1_fill_valid   = 1'b1;
        l1_fill_line    = fill_line_q;
        l1_fill_from_vc = from_vc_q;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign vc_wr_err  = wr_err_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule
